fifo_cmd_reader: RTL

Sequences reads from the external IDT7201-style FIFO and decodes the byte stream into display configuration commands. Sits between the FIFO pins (-RD, -EF, D[7:0]) and the VGA timing/pixel logic, in the 240 MHz PLL clock domain. Generates -RD strobes with programmable low/high widths and synchronizes -EF. Emits register writes, a foreground colour, and a back-pressured pixel byte stream.

---
 rtl/fifo_cmd_reader_if.sv | 28 ++
 rtl/fifo_cmd_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_cmd_reader_if.sv
// Signal bundle between the IDT7201-style FIFO pins, the command reader and the
// VGA timing/pixel logic. The reader connects through the slave modport.
interface fifo_cmd_reader_if;
  logic       fifo_ef;
  logic [7:0] fifo_d;
  logic       fifo_rd;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;
  logic [3:0] fg_red;
  logic [3:0] fg_green;
  logic [3:0] fg_blue;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;

  modport slave (
    input  fifo_ef, fifo_d, pix_ready,
    output fifo_rd, reg_we, reg_addr, reg_data,
           fg_red, fg_green, fg_blue, pix_valid, pix_data
  );

  modport master (
    output fifo_ef, fifo_d, pix_ready,
    input  fifo_rd, reg_we, reg_addr, reg_data,
           fg_red, fg_green, fg_blue, pix_valid, pix_data
  );
endinterface

// File: rtl/fifo_cmd_reader.sv
// Strobes -RD on the external FIFO with programmable low/high widths and decodes
// the byte stream into register writes, a foreground colour and pixel bytes.
module fifo_cmd_reader #(
  parameter int unsigned RD_LOW_CYCLES  = 8,
  parameter int unsigned RD_HIGH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             disp_rst,
  fifo_cmd_reader_if.slave bus
);

  typedef enum logic [1:0] {RD_IDLE, RD_LOW, RD_HIGH} rd_state_e;
  typedef enum logic [2:0] {P_CMD, P_COL1, P_COL2, P_REGD, P_BURST} p_state_e;

  localparam logic [3:0] LOW_LAST  = 4'(RD_LOW_CYCLES - 1);
  // The IDLE cycle before the next strobe is the last of the -RD high cycles.
  localparam logic [3:0] HIGH_LAST = 4'(RD_HIGH_CYCLES - 2);

  logic       ef_s1_q, ef_s2_q;
  rd_state_e  rd_state_q, rd_state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fifo_rd_q, fifo_rd_d;
  p_state_e   p_state_q, p_state_d;
  logic [5:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] hold_r_q, hold_r_d;
  logic [3:0] hold_g_q, hold_g_d;
  logic       reg_we_q, reg_we_d;
  logic [3:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_data_q, reg_data_d;
  logic [3:0] fg_red_q, fg_red_d;
  logic [3:0] fg_green_q, fg_green_d;
  logic [3:0] fg_blue_q, fg_blue_d;
  logic       pix_valid_q, pix_valid_d;
  logic [7:0] pix_data_q, pix_data_d;
  logic       capture;
  logic       stall;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rd_state_d  = rd_state_q;
    cnt_d       = cnt_q;
    fifo_rd_d   = fifo_rd_q;
    p_state_d   = p_state_q;
    burst_cnt_d = burst_cnt_q;
    hold_r_d    = hold_r_q;
    hold_g_d    = hold_g_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    fg_red_d    = fg_red_q;
    fg_green_d  = fg_green_q;
    fg_blue_d   = fg_blue_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    capture     = 1'b0;
    stall       = pix_valid_q && !bus.pix_ready;

    if (pix_valid_q && bus.pix_ready) pix_valid_d = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (ef_s2_q && !stall) begin
          rd_state_d = RD_LOW;
          cnt_d      = '0;
          fifo_rd_d  = 1'b0;
        end
      end
      RD_LOW: begin
        if (cnt_q == LOW_LAST) begin
          capture    = 1'b1;
          fifo_rd_d  = 1'b1;
          rd_state_d = RD_HIGH;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HIGH: begin
        if (cnt_q == HIGH_LAST) rd_state_d = RD_IDLE;
        else                    cnt_d      = cnt_q + 4'd1;
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // The captured byte is decoded straight off the pins so its effect is
    // visible in the first RD_HIGH cycle.
    if (capture) begin
      case (p_state_q)
        P_CMD: begin
          case (bus.fifo_d[7:6])
            2'b00: p_state_d = P_CMD;
            2'b01: p_state_d = P_COL1;
            2'b10: begin
              reg_addr_d = bus.fifo_d[3:0];
              p_state_d  = P_REGD;
            end
            default: begin
              burst_cnt_d = bus.fifo_d[5:0];
              p_state_d   = P_BURST;
            end
          endcase
        end
        P_COL1: begin
          hold_r_d  = bus.fifo_d[7:4];
          hold_g_d  = bus.fifo_d[3:0];
          p_state_d = P_COL2;
        end
        P_COL2: begin
          fg_red_d   = hold_r_q;
          fg_green_d = hold_g_q;
          fg_blue_d  = bus.fifo_d[7:4];
          p_state_d  = P_CMD;
        end
        P_REGD: begin
          reg_data_d = bus.fifo_d;
          reg_we_d   = 1'b1;
          p_state_d  = P_CMD;
        end
        P_BURST: begin
          pix_data_d  = bus.fifo_d;
          pix_valid_d = 1'b1;
          if (burst_cnt_q == '0) p_state_d   = P_CMD;
          else                   burst_cnt_d = burst_cnt_q - 6'd1;
        end
        default: p_state_d = P_CMD;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; the reset here is synchronous, so it only
  // acts on a clock edge.
  always_ff @(posedge clk) begin
    if (!disp_rst) begin
      ef_s1_q     <= 1'b0;
      ef_s2_q     <= 1'b0;
      rd_state_q  <= RD_IDLE;
      cnt_q       <= '0;
      fifo_rd_q   <= 1'b1;
      p_state_q   <= P_CMD;
      burst_cnt_q <= '0;
      hold_r_q    <= '0;
      hold_g_q    <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      fg_red_q    <= '0;
      fg_green_q  <= '0;
      fg_blue_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      ef_s1_q     <= bus.fifo_ef;
      ef_s2_q     <= ef_s1_q;
      rd_state_q  <= rd_state_d;
      cnt_q       <= cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      p_state_q   <= p_state_d;
      burst_cnt_q <= burst_cnt_d;
      hold_r_q    <= hold_r_d;
      hold_g_q    <= hold_g_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      fg_red_q    <= fg_red_d;
      fg_green_q  <= fg_green_d;
      fg_blue_q   <= fg_blue_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign bus.fifo_rd   = fifo_rd_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.fg_red    = fg_red_q;
  assign bus.fg_green  = fg_green_q;
  assign bus.fg_blue   = fg_blue_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;

endmodule
